// File: rtl/alu_operand_stage.sv
// Operand/issue stage feeding a combinational 16-bit ALU: register file, carry flag,
// registered ALU inputs, one-cycle-later write-back and back-to-back result forwarding.
module alu_operand_stage #(
  parameter int DATA_W = 16,
  parameter int NREG   = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [AW-1:0]     in_rs,
  input  logic [AW-1:0]     in_rt,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_use_cf,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_cout,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_addr,
  output logic              cf,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  typedef enum logic {S_IDLE = 1'b0, S_EX = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic              cf_q, cf_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              alu_cin_q, alu_cin_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [AW-1:0]     wb_addr_q, wb_addr_d;

  logic              accept;
  logic              ex_valid;
  logic              ex_sets_cf;
  logic [DATA_W-1:0] op_a, op_b;
  logic              cf_fwd;

  assign in_ready   = !ld_en && !reset;
  assign accept     = in_valid && in_ready;
  assign ex_valid   = (state_q == S_EX);
  assign ex_sets_cf = (alu_op_q == OP_ADD) || (alu_op_q == OP_SUB);

  // The instruction in EX has not written back yet, so a dependent issue takes its
  // result (and carry) straight from the ALU outputs instead of stalling.
  assign op_a   = (ex_valid && wb_addr_q == in_rs) ? alu_c : rf_q[in_rs];
  assign op_b   = (ex_valid && wb_addr_q == in_rt) ? alu_c : rf_q[in_rt];
  assign cf_fwd = (ex_valid && ex_sets_cf) ? alu_cout : cf_q;

  // NOTE: every variable assigned here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = accept ? S_EX : S_IDLE;
    rf_d      = rf_q;
    cf_d      = cf_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_cin_d = alu_cin_q;
    alu_op_d  = alu_op_q;
    wb_addr_d = wb_addr_q;

    if (ex_valid) begin
      rf_d[wb_addr_q] = alu_c;
      if (ex_sets_cf) cf_d = alu_cout;
    end
    // Applied after the write-back so a direct load to the same register wins.
    if (ld_en) rf_d[ld_addr] = ld_data;

    if (accept) begin
      alu_a_d   = op_a;
      alu_b_d   = op_b;
      alu_cin_d = in_use_cf ? cf_fwd : 1'b0;
      alu_op_d  = in_op;
      wb_addr_d = in_rd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the register file
  // is deliberately included in the reset because its cleared contents are visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cf_q      <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_cin_q <= 1'b0;
      alu_op_q  <= '0;
      wb_addr_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cf_q      <= cf_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_cin_q <= alu_cin_d;
      alu_op_q  <= alu_op_d;
      wb_addr_q <= wb_addr_d;
      rf_q      <= rf_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_cin  = alu_cin_q;
  assign alu_op   = alu_op_q;
  assign wb_addr  = wb_addr_q;
  assign wb_valid = ex_valid;
  assign cf       = cf_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: behavioural ALU, sequential-ISA reference model with
// per-cycle comparison, and directed vectors with hand-computed expectations.
module tb_alu_operand_stage;

  logic        clk, reset;
  logic        in_valid, in_ready, in_use_cf, ld_en;
  logic [3:0]  in_op, alu_op;
  logic [1:0]  in_rs, in_rt, in_rd, ld_addr, wb_addr, dbg_addr;
  logic [15:0] ld_data, alu_a, alu_b, alu_c, dbg_data;
  logic        alu_cin, alu_cout, wb_valid, cf;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(.DATA_W(16), .NREG(4), .AW(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_use_cf(in_use_cf),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_c(alu_c), .alu_cout(alu_cout),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .cf(cf),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {cout, result}; SUB carry-out is the borrow.
  function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    case (op)
      4'b0000: alu_f = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      4'b0001: alu_f = {1'b0, a} - {1'b0, b} - {16'd0, cin};
      4'b0010: alu_f = {1'b0, a & b};
      4'b0011: alu_f = {1'b0, a | b};
      4'b1111: alu_f = {1'b0, a ^ b};
      default: alu_f = {1'b0, a};
    endcase
  endfunction

  always_comb {alu_cout, alu_c} = alu_f(alu_op, alu_a, alu_b, alu_cin);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec_* is the register state with every accepted instruction
  // completed in program order; vis_* is what is observable, trailing by the pipeline.
  typedef struct packed {
    logic        v;
    logic [1:0]  rd;
    logic [15:0] a, b;
    logic        cin;
    logic [3:0]  op;
    logic [15:0] c;
    logic        cout;
  } pend_t;

  logic [15:0] spec_rf [4];
  logic [15:0] vis_rf  [4];
  logic        spec_cf, vis_cf;
  pend_t       pend;

  always @(posedge clk or posedge reset) begin : model
    pend_t      nxt;
    logic [16:0] r;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin spec_rf[i] = '0; vis_rf[i] = '0; end
      spec_cf = 1'b0;
      vis_cf  = 1'b0;
      pend    = '0;
    end else begin
      nxt = '0;
      if (pend.v) begin
        vis_rf[pend.rd] = pend.c;
        if (pend.op == 4'd0 || pend.op == 4'd1) vis_cf = pend.cout;
      end
      if (in_valid && !ld_en) begin
        nxt.v   = 1'b1;
        nxt.rd  = in_rd;
        nxt.op  = in_op;
        nxt.a   = spec_rf[in_rs];
        nxt.b   = spec_rf[in_rt];
        nxt.cin = in_use_cf ? spec_cf : 1'b0;
        r = alu_f(in_op, nxt.a, nxt.b, nxt.cin);
        nxt.c    = r[15:0];
        nxt.cout = r[16];
        spec_rf[in_rd] = r[15:0];
        if (in_op == 4'd0 || in_op == 4'd1) spec_cf = r[16];
      end
      if (ld_en) begin
        vis_rf[ld_addr]  = ld_data;
        spec_rf[ld_addr] = ld_data;
      end
      pend = nxt;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !ld_en});
      check("wb_valid", {31'd0, wb_valid}, {31'd0, pend.v});
      check("cf", {31'd0, cf}, {31'd0, vis_cf});
      check("dbg_data", {16'd0, dbg_data}, {16'd0, vis_rf[dbg_addr]});
      if (pend.v) begin
        check("alu_a", {16'd0, alu_a}, {16'd0, pend.a});
        check("alu_b", {16'd0, alu_b}, {16'd0, pend.b});
        check("alu_cin", {31'd0, alu_cin}, {31'd0, pend.cin});
        check("alu_op", {28'd0, alu_op}, {28'd0, pend.op});
        check("wb_addr", {30'd0, wb_addr}, {30'd0, pend.rd});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] addr, input logic [15:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  // Leaves in_valid high so consecutive calls issue back-to-back.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input logic ucf);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_use_cf = ucf;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic reg_chk(input string name, input logic [1:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check(name, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_use_cf = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // 1: simple add
    load(2'd0, 16'd2);
    load(2'd1, 16'd3);
    issue(4'b0000, 2'd2, 2'd0, 2'd1, 1'b0);
    check("t1_alu_a", {16'd0, alu_a}, 32'd2);
    check("t1_alu_b", {16'd0, alu_b}, 32'd3);
    idle();
    reg_chk("t1_r2", 2'd2, 16'd5);
    check("t1_cf", {31'd0, cf}, 32'd0);

    // 2: back-to-back dependency forwarded from the ALU
    issue(4'b0000, 2'd2, 2'd0, 2'd1, 1'b0);
    issue(4'b0000, 2'd3, 2'd2, 2'd2, 1'b0);
    check("t2_fwd_a", {16'd0, alu_a}, 32'd5);
    check("t2_fwd_b", {16'd0, alu_b}, 32'd5);
    idle();
    reg_chk("t2_r3", 2'd3, 16'd10);

    // 3: carry out and forwarded carry in
    load(2'd0, 16'hffff);
    load(2'd1, 16'd1);
    issue(4'b0000, 2'd2, 2'd0, 2'd1, 1'b0);
    issue(4'b0000, 2'd3, 2'd1, 2'd1, 1'b1);
    check("t3_fwd_cin", {31'd0, alu_cin}, 32'd1);
    check("t3_cf_set", {31'd0, cf}, 32'd1);
    reg_chk("t3_r2", 2'd2, 16'd0);
    idle();
    reg_chk("t3_r3", 2'd3, 16'd3);
    check("t3_cf_clr", {31'd0, cf}, 32'd0);

    // 4: non-arithmetic op keeps cf; SUB borrow sets it
    issue(4'b0000, 2'd2, 2'd0, 2'd1, 1'b0);
    idle();
    check("t4_cf_pre", {31'd0, cf}, 32'd1);
    issue(4'b1111, 2'd0, 2'd0, 2'd1, 1'b0);
    idle();
    reg_chk("t4_xor", 2'd0, 16'hfffe);
    check("t4_cf_xor", {31'd0, cf}, 32'd1);
    issue(4'b0000, 2'd3, 2'd1, 2'd1, 1'b0);
    idle();
    check("t4_cf_cleared", {31'd0, cf}, 32'd0);
    issue(4'b0001, 2'd3, 2'd2, 2'd1, 1'b0);
    idle();
    reg_chk("t4_sub", 2'd3, 16'hffff);
    check("t4_cf_sub", {31'd0, cf}, 32'd1);

    // 5: load blocks issue; same-address load beats write-back, different both land
    issue(4'b0000, 2'd2, 2'd1, 2'd1, 1'b0);
    in_rd = 2'd0; ld_en = 1'b1; ld_addr = 2'd2; ld_data = 16'h1234;
    #1;
    check("t5_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    ld_en = 1'b0; in_valid = 1'b0;
    check("t5_no_accept", {31'd0, wb_valid}, 32'd0);
    reg_chk("t5_ld_wins", 2'd2, 16'h1234);
    reg_chk("t5_r0_kept", 2'd0, 16'hfffe);
    issue(4'b0000, 2'd3, 2'd1, 2'd1, 1'b0);
    in_valid = 1'b0;
    load(2'd0, 16'd7);
    reg_chk("t5_both_r3", 2'd3, 16'd2);
    reg_chk("t5_both_r0", 2'd0, 16'd7);

    // 6: reset during EX drops the write-back and clears everything
    issue(4'b0000, 2'd1, 2'd0, 2'd0, 1'b0);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("t6_alu_a", {16'd0, alu_a}, 32'd0);
    check("t6_alu_b", {16'd0, alu_b}, 32'd0);
    check("t6_alu_op", {28'd0, alu_op}, 32'd0);
    check("t6_alu_cin", {31'd0, alu_cin}, 32'd0);
    check("t6_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("t6_cf", {31'd0, cf}, 32'd0);
    for (int i = 0; i < 4; i++) reg_chk("t6_reg", i[1:0], 16'd0);
    tick();
    reset = 1'b0;
    tick();
    reg_chk("t6_no_wb", 2'd1, 16'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
